// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared constants and helpers for the fetch stage
//
// Purpose : reset PC, instruction-memory window and next-PC select encodings
//           used by pc_fetch and npc.
// Ports   : none (package)
package pc_fetch_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFF;

  localparam logic [1:0] NPC_SEL_SEQ = 2'b00;
  localparam logic [1:0] NPC_SEL_BR  = 2'b01;
  localparam logic [1:0] NPC_SEL_J   = 2'b10;
  localparam logic [1:0] NPC_SEL_JR  = 2'b11;

  // Sign-extended word offset of a branch immediate.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_npc.sv
// rtl/pc_fetch_npc.sv - combinational next-PC selection
//
// Purpose : computes the next fetch address from the select code and the
//           fields of the instruction currently in ID.
// Ports   : npc_sel, valid_d      - select code, ignored when ID holds a bubble
//           pc_f, pc_d            - fetch PC and ID-stage PC
//           imm16_d, index26_d    - branch offset / jump index fields
//           rs_val_d              - jump-register target
//           npc                   - next fetch address
module npc
  import pc_fetch_pkg::*;
(
  input  logic [1:0]  npc_sel,
  input  logic        valid_d,
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16_d,
  input  logic [25:0] index26_d,
  input  logic [31:0] rs_val_d,
  output logic [31:0] npc
);

  logic [1:0] sel;

  // A bubble in ID cannot redirect fetch.
  assign sel = valid_d ? npc_sel : NPC_SEL_SEQ;

  always_comb begin
    npc = pc_f + 32'd4;
    case (sel)
      NPC_SEL_BR:  npc = pc_d + 32'd4 + br_offset(imm16_d);
      NPC_SEL_J:   npc = {pc_d[31:28], index26_d, 2'b00};
      NPC_SEL_JR:  npc = rs_val_d;
      default:     npc = pc_f + 32'd4;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register and IF/ID pipeline register
//
// Purpose : holds the fetch PC and the IF/ID latch; redirects take effect
//           after the delay-slot instruction, so nothing is squashed.
// Config  : PC_ALIGN_CHECK_EN enables the fetch address error check (adel_d).
// Ports   : clk, reset (sync, active low), stall
//           npc_sel, imm16_d, index26_d, rs_val_d - redirect controls from ID
//           instr_f                               - memory data for pc_f
//           pc_f                                  - fetch address
//           instr_d, pc_d, pc8_d, valid_d, adel_d - IF/ID outputs
module pc_fetch
  import pc_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] imm16_d,
  input  logic [25:0] index26_d,
  input  logic [31:0] rs_val_d,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        adel_d
);

  logic [31:0] npc_val;

  npc u_npc (
    .npc_sel   (npc_sel),
    .valid_d   (valid_d),
    .pc_f      (pc_f),
    .pc_d      (pc_d),
    .imm16_d   (imm16_d),
    .index26_d (index26_d),
    .rs_val_d  (rs_val_d),
    .npc       (npc_val)
  );

  assign pc8_d = pc_d + 32'd8;

`ifdef PC_ALIGN_CHECK_EN
  logic bad_addr;

  assign bad_addr = (pc_f[1:0] != 2'b00) || (pc_f < IM_LO) || (pc_f > IM_HI);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f    <= PC_RESET;
      pc_d    <= 32'h0;
      instr_d <= 32'h0;
      valid_d <= 1'b0;
      adel_d  <= 1'b0;
    end else if (!stall) begin
      pc_f    <= npc_val;
      pc_d    <= pc_f;
      valid_d <= 1'b1;
      adel_d  <= bad_addr;
      // A faulting fetch enters ID as a nop.
      instr_d <= bad_addr ? 32'h0 : instr_f;
    end
  end
`else
  assign adel_d = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f    <= PC_RESET;
      pc_d    <= 32'h0;
      instr_d <= 32'h0;
      valid_d <= 1'b0;
    end else if (!stall) begin
      pc_f    <= npc_val;
      pc_d    <= pc_f;
      instr_d <= instr_f;
      valid_d <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic [15:0] imm16_d;
  logic [25:0] index26_d;
  logic [31:0] rs_val_d;
  logic [31:0] instr_f;
  logic [31:0] pc_f, instr_d, pc_d, pc8_d;
  logic        valid_d, adel_d;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Instruction memory model: a distinct word per address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  assign instr_f = mem(pc_f);

  pc_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .npc_sel   (npc_sel),
    .imm16_d   (imm16_d),
    .index26_d (index26_d),
    .rs_val_d  (rs_val_d),
    .instr_f   (instr_f),
    .pc_f      (pc_f),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d),
    .valid_d   (valid_d),
    .adel_d    (adel_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; npc_sel = 2'b00;
    imm16_d = 16'h0; index26_d = 26'h0; rs_val_d = 32'h0;
    tick(); tick();
    total++; if (pc_f !== 32'h3000) $display("FAIL rst_pc_f got %h want 00003000", pc_f); else passed++;
    total++; if (pc_d !== 32'h0) $display("FAIL rst_pc_d got %h want 00000000", pc_d); else passed++;
    total++; if (instr_d !== 32'h0) $display("FAIL rst_instr_d got %h want 00000000", instr_d); else passed++;
    total++; if (valid_d !== 1'b0) $display("FAIL rst_valid got %b want 0", valid_d); else passed++;
    total++; if (adel_d !== 1'b0) $display("FAIL rst_adel got %b want 0", adel_d); else passed++;
    reset = 1'b1;
    tick();
    total++; if (pc_f !== 32'h3004) $display("FAIL seq1_pc_f got %h want 00003004", pc_f); else passed++;
    total++; if (valid_d !== 1'b1) $display("FAIL seq1_valid got %b want 1", valid_d); else passed++;
    total++; if (pc_d !== 32'h3000) $display("FAIL seq1_pc_d got %h want 00003000", pc_d); else passed++;
    total++; if (instr_d !== mem(32'h3000)) $display("FAIL seq1_instr got %h want %h", instr_d, mem(32'h3000)); else passed++;
    total++; if (pc8_d !== 32'h3008) $display("FAIL seq1_pc8 got %h want 00003008", pc8_d); else passed++;
    tick();
    total++; if (pc_f !== 32'h3008) $display("FAIL seq2_pc_f got %h want 00003008", pc_f); else passed++;
  endtask

  task automatic test_branch();
    tick(); tick(); tick();  // pc_f 0x3014, pc_d 0x3010
    total++; if (pc_d !== 32'h3010) $display("FAIL br_setup_pc_d got %h want 00003010", pc_d); else passed++;
    npc_sel = 2'b01; imm16_d = 16'hFFFC;
    tick();
    npc_sel = 2'b00;
    total++; if (pc_f !== 32'h3004) $display("FAIL br_pc_f got %h want 00003004", pc_f); else passed++;
    total++; if (pc_d !== 32'h3014) $display("FAIL br_slot_pc_d got %h want 00003014", pc_d); else passed++;
    total++; if (instr_d !== mem(32'h3014)) $display("FAIL br_slot_instr got %h want %h", instr_d, mem(32'h3014)); else passed++;
  endtask

  task automatic test_jump();
    npc_sel = 2'b11; rs_val_d = 32'h3020;
    tick();
    npc_sel = 2'b00;
    tick();  // pc_d 0x3020
    total++; if (pc_d !== 32'h3020) $display("FAIL j_setup_pc_d got %h want 00003020", pc_d); else passed++;
    npc_sel = 2'b10; index26_d = 26'h0000C40;
    tick();
    total++; if (pc_f !== 32'h3100) $display("FAIL j_pc_f got %h want 00003100", pc_f); else passed++;
    npc_sel = 2'b11; rs_val_d = 32'h0000_3ABC;
    tick();
    npc_sel = 2'b00;
    total++; if (pc_f !== 32'h3ABC) $display("FAIL jr_pc_f got %h want 00003abc", pc_f); else passed++;
    total++; if (pc_d !== 32'h3100) $display("FAIL jr_pc_d got %h want 00003100", pc_d); else passed++;
  endtask

  task automatic test_stall();
    tick();  // pc_f 0x3AC0, pc_d 0x3ABC
    stall = 1'b1; npc_sel = 2'b01; imm16_d = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc_f !== 32'h3AC0) $display("FAIL stall_pc_f[%0d] got %h want 00003ac0", i, pc_f); else passed++;
      total++; if (pc_d !== 32'h3ABC) $display("FAIL stall_pc_d[%0d] got %h want 00003abc", i, pc_d); else passed++;
      total++; if (instr_d !== mem(32'h3ABC)) $display("FAIL stall_instr[%0d] got %h want %h", i, instr_d, mem(32'h3ABC)); else passed++;
    end
    stall = 1'b0;
    tick();
    npc_sel = 2'b00;
    total++; if (pc_f !== 32'h3AD0) $display("FAIL stall_rel_pc_f got %h want 00003ad0", pc_f); else passed++;
    tick();
    total++; if (pc_f !== 32'h3AD4) $display("FAIL stall_once_pc_f got %h want 00003ad4", pc_f); else passed++;
  endtask

  task automatic test_reset_priority();
    stall = 1'b1; npc_sel = 2'b01; reset = 1'b0;
    tick();
    total++; if (pc_f !== 32'h3000) $display("FAIL rstpri_pc_f got %h want 00003000", pc_f); else passed++;
    total++; if (valid_d !== 1'b0) $display("FAIL rstpri_valid got %b want 0", valid_d); else passed++;
    // Bubble in ID: a jr request must be ignored.
    stall = 1'b0; reset = 1'b1; npc_sel = 2'b11; rs_val_d = 32'h5000;
    tick();
    total++; if (pc_f !== 32'h3004) $display("FAIL bubble_sel_pc_f got %h want 00003004", pc_f); else passed++;
    npc_sel = 2'b00;
  endtask

  task automatic test_wrap();
    npc_sel = 2'b11; rs_val_d = 32'hFFFF_FFF0;
    tick();
    npc_sel = 2'b00;
    tick();  // pc_d 0xFFFF_FFF0
    total++; if (pc8_d !== 32'hFFFF_FFF8) $display("FAIL wrap_pc8 got %h want fffffff8", pc8_d); else passed++;
    npc_sel = 2'b01; imm16_d = 16'h0010;
    tick();
    npc_sel = 2'b00;
    total++; if (pc_f !== 32'h0000_0034) $display("FAIL wrap_pc_f got %h want 00000034", pc_f); else passed++;
  endtask

  task automatic test_addr_check();
    reset = 1'b0; tick(); reset = 1'b1; tick();
    npc_sel = 2'b11; rs_val_d = 32'h0000_3002;
    tick();
    npc_sel = 2'b00;
    tick();  // pc_d 0x3002
`ifdef PC_ALIGN_CHECK_EN
    total++; if (adel_d !== 1'b1) $display("FAIL adel_unaligned got %b want 1", adel_d); else passed++;
    total++; if (instr_d !== 32'h0) $display("FAIL adel_instr got %h want 00000000", instr_d); else passed++;
`else
    total++; if (adel_d !== 1'b0) $display("FAIL adel_unaligned got %b want 0", adel_d); else passed++;
    total++; if (instr_d !== mem(32'h3002)) $display("FAIL adel_instr got %h want %h", instr_d, mem(32'h3002)); else passed++;
`endif
    npc_sel = 2'b11; rs_val_d = 32'h0000_7000;
    tick();
    npc_sel = 2'b00;
    tick();  // pc_d 0x7000
    total++; if (pc_d !== 32'h7000) $display("FAIL adel_hi_pc_d got %h want 00007000", pc_d); else passed++;
`ifdef PC_ALIGN_CHECK_EN
    total++; if (adel_d !== 1'b1) $display("FAIL adel_range got %b want 1", adel_d); else passed++;
`else
    total++; if (adel_d !== 1'b0) $display("FAIL adel_range got %b want 0", adel_d); else passed++;
`endif
    npc_sel = 2'b11; rs_val_d = 32'h0000_6FFC;
    tick();
    npc_sel = 2'b00;
    tick();  // pc_d 0x6FFC, last legal word
    total++; if (adel_d !== 1'b0) $display("FAIL adel_edge got %b want 0", adel_d); else passed++;
    total++; if (instr_d !== mem(32'h6FFC)) $display("FAIL adel_edge_instr got %h want %h", instr_d, mem(32'h6FFC)); else passed++;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_reset_priority();
    test_wrap();
    test_addr_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-003 SHALL have port stall, input, 1 bit: hazard unit stall request; 1 holds the PC and the IF/ID register.
REQ-004 SHALL have port npc_sel, input, 2 bits: 00 sequential, 01 branch taken, 10 jump index (j/jal), 11 jump register (jr/jalr).
REQ-005 SHALL have port imm16_d, input, 16 bits: branch offset field of the instruction in ID.
REQ-006 SHALL have port index26_d, input, 26 bits: jump index field of the instruction in ID.
REQ-007 SHALL have port rs_val_d, input, 32 bits: forwarded rs value for the jump-register target.
REQ-008 SHALL have port instr_f, input, 32 bits: instruction word returned by instruction memory for pc_f.
REQ-009 SHALL have port pc_f, output, 32 bits: current fetch address driven to instruction memory.
REQ-010 SHALL have port instr_d, output, 32 bits: IF/ID latched instruction.
REQ-011 SHALL have port pc_d, output, 32 bits: IF/ID latched PC.
REQ-012 SHALL have port pc8_d, output, 32 bits: pc_d + 8 (link value), combinational.
REQ-013 SHALL have port valid_d, output, 1 bit: IF/ID holds a real fetched instruction.
REQ-014 SHALL have port adel_d, output, 1 bit: fetch address error for the instruction in ID.

Function
REQ-015 SHALL compute npc combinationally as follows: 00 -> pc_f+4; 01 -> pc_d+4+(sign_ext(imm16_d)<<2); 10 -> {pc_d[31:28], index26_d, 2'b00}; 11 -> rs_val_d.
REQ-016 SHALL perform all PC arithmetic modulo 2^32, with silent wrap-around and no overflow flag.
REQ-017 SHALL treat npc_sel as 00 whenever valid_d=0.
REQ-018 SHALL, on a rising edge with reset=1 and stall=0, update pc_f<=npc, instr_d<=instr_f, pc_d<=pc_f, valid_d<=1.
REQ-019 SHALL, on a rising edge with reset=1 and stall=1, hold pc_f, instr_d, pc_d, valid_d and adel_d, ignoring npc_sel.
REQ-020 SHALL give the one-instruction branch delay slot by construction: the redirect takes effect on the fetch after the delay-slot instruction and squashes nothing.
REQ-021 SHALL have a latency of exactly 1 cycle from pc_f to the corresponding instr_d/pc_d.
REQ-022 SHALL let reset take priority over stall and redirect in the same cycle.

Reset
REQ-023 SHALL, on a rising edge with reset=0, set pc_f=32'h0000_3000, pc_d=32'h0000_0000, instr_d=32'h0000_0000 (nop), valid_d=0 and adel_d=0.
REQ-024 SHALL, when reset is asserted mid-stall or mid-redirect, abandon the pending redirect; fetch SHALL restart at 0x3000 on the first cycle with reset=1.

Configuration
REQ-025 SHALL, with macro PC_ALIGN_CHECK_EN defined, latch adel_d<=1 and instr_d<=0 on a non-stalled edge when pc_f[1:0]!=0 or pc_f is outside [0x3000, 0x6FFF]; otherwise adel_d<=0.
REQ-026 SHALL, without PC_ALIGN_CHECK_EN, tie adel_d to constant 0 and pass instr_f through unmodified.

Structure
REQ-027 SHALL take the following from the shared package: PC_RESET (0x3000), IM_LO (0x3000), IM_HI (0x6FFF) and the NPC_SEL_SEQ/BR/J/JR encodings.
REQ-028 SHALL contain exactly one sub-module, npc, that is purely combinational and implements REQ-015/017; all registers SHALL reside in pc_fetch.

Verification
REQ-029 SHALL pass this reset scenario: reset=0 for 2 cycles, then 1 with npc_sel=00 -> pc_f 0x3000, 0x3004, 0x3008; valid_d=0 in the first cycle after release, then 1.
REQ-030 SHALL pass this branch scenario: pc_d=0x3010, npc_sel=01, imm16_d=0xFFFC -> next pc_f=0x3004; the delay-slot instr at 0x3014 appears in instr_d.
REQ-031 SHALL pass this jump scenario: pc_d=0x3020, npc_sel=10, index26_d=0x0000C40 -> pc_f=0x3100; with npc_sel=11 and rs_val_d=0x0000_3ABC -> pc_f=0x3ABC.
REQ-032 SHALL pass this stall scenario: stall=1 for 3 cycles with npc_sel=01 -> pc_f, instr_d, pc_d unchanged; on release, the redirect applies exactly once.
REQ-033 SHALL pass this address-check scenario (PC_ALIGN_CHECK_EN): jr to 0x0000_3002 -> adel_d=1 and instr_d=0 next edge; jr to 0x7000 -> adel_d=1; without the macro -> adel_d stays 0.
REQ-034 SHALL pass this wrap scenario: pc_d=0xFFFF_FFF0, npc_sel=01, imm16_d=0x0010 -> pc_f=0x0000_0034.
